// File: rtl/timer_irq_ctrl.sv
// Interrupt aggregator for up to NUM_SRC timer interrupt lines: edge capture, pending/mask/overrun, saturating event count.
// Define TIMER_IRQ_CTRL_SYNC_EN to pass irq_src through a 2-flop synchronizer for sources on a foreign clock.
module timer_irq_ctrl #(
  parameter int NUM_SRC = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [1:0]         avmms_address,
  input  logic               avmms_write,
  input  logic [31:0]        avmms_writedata,
  input  logic [3:0]         avmms_byteenable,
  input  logic               avmms_read,
  output logic [31:0]        avmms_readdata,
  output logic               coe_irq
);

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_OVERRUN = 2'd2;
  localparam logic [1:0] ADDR_EVENT   = 2'd3;

  logic [NUM_SRC-1:0] src_in;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] enable_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] overrun_q;
  logic [31:0]        event_cnt_q;

`ifdef TIMER_IRQ_CTRL_SYNC_EN
  logic [NUM_SRC-1:0] sync_q1;
  logic [NUM_SRC-1:0] sync_q2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_src;
      sync_q2 <= sync_q1;
    end
  end

  assign src_in = sync_q2;
`else
  assign src_in = irq_src;
`endif

  logic [31:0]        be_mask;
  logic [31:0]        wdata_m;
  logic               wr_enable;
  logic               wr_pending;
  logic               wr_overrun;
  logic               wr_event;
  logic [NUM_SRC-1:0] src_edge;
  logic [NUM_SRC-1:0] pend_clr;
  logic [NUM_SRC-1:0] ovr_clr;
  logic [NUM_SRC-1:0] enable_next;
  logic [NUM_SRC-1:0] pending_next;
  logic [NUM_SRC-1:0] overrun_next;
  logic [5:0]         edge_cnt;
  logic [31:0]        cnt_base;
  logic [32:0]        cnt_sum;
  logic [31:0]        cnt_next;
  logic [31:0]        rd_mux;
  logic               unused_wdata;

  // Disabled byte lanes contribute zero data, so W1C never clears through them.
  assign be_mask = {{8{avmms_byteenable[3]}}, {8{avmms_byteenable[2]}},
                    {8{avmms_byteenable[1]}}, {8{avmms_byteenable[0]}}};
  assign wdata_m = avmms_writedata & be_mask;
  assign unused_wdata = ^wdata_m;

  assign wr_enable  = avmms_write && (avmms_address == ADDR_ENABLE);
  assign wr_pending = avmms_write && (avmms_address == ADDR_PENDING);
  assign wr_overrun = avmms_write && (avmms_address == ADDR_OVERRUN);
  assign wr_event   = avmms_write && (avmms_address == ADDR_EVENT) && (avmms_byteenable != 4'h0);

  assign src_edge = src_in & ~src_q;
  assign pend_clr = wr_pending ? wdata_m[NUM_SRC-1:0] : '0;
  assign ovr_clr  = wr_overrun ? wdata_m[NUM_SRC-1:0] : '0;

  assign enable_next = wr_enable
                     ? ((enable_q & ~be_mask[NUM_SRC-1:0]) | wdata_m[NUM_SRC-1:0])
                     : enable_q;

  // A new edge beats a same-cycle clear and then does not count as an overrun.
  assign pending_next = (pending_q & ~pend_clr) | src_edge;
  assign overrun_next = (overrun_q & ~ovr_clr) | (src_edge & pending_q & ~pend_clr);

  always_comb begin
    edge_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      edge_cnt = edge_cnt + 6'(src_edge[i]);
    end
  end

  assign cnt_base = wr_event ? 32'd0 : event_cnt_q;
  assign cnt_sum  = {1'b0, cnt_base} + {27'd0, edge_cnt};
  assign cnt_next = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];

  always_comb begin
    rd_mux = '0;
    case (avmms_address)
      ADDR_ENABLE:  rd_mux[NUM_SRC-1:0] = enable_q;
      ADDR_PENDING: rd_mux[NUM_SRC-1:0] = pending_q;
      ADDR_OVERRUN: rd_mux[NUM_SRC-1:0] = overrun_q;
      default:      rd_mux = event_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q          <= '0;
      enable_q       <= '0;
      pending_q      <= '0;
      overrun_q      <= '0;
      event_cnt_q    <= '0;
      avmms_readdata <= '0;
      coe_irq        <= 1'b0;
    end else begin
      src_q       <= src_in;
      enable_q    <= enable_next;
      pending_q   <= pending_next;
      overrun_q   <= overrun_next;
      event_cnt_q <= cnt_next;
      coe_irq     <= |(pending_q & enable_q);
      if (avmms_read) begin
        avmms_readdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Self-checking bench for timer_irq_ctrl: table of register/interrupt vectors plus hand sequences for saturation and reset.
module tb_timer_irq_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  irq_src;
  logic [1:0]  avmms_address;
  logic        avmms_write;
  logic [31:0] avmms_writedata;
  logic [3:0]  avmms_byteenable;
  logic        avmms_read;
  logic [31:0] avmms_readdata;
  logic        coe_irq;

  timer_irq_ctrl #(.NUM_SRC(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .irq_src          (irq_src),
    .avmms_address    (avmms_address),
    .avmms_write      (avmms_write),
    .avmms_writedata  (avmms_writedata),
    .avmms_byteenable (avmms_byteenable),
    .avmms_read       (avmms_read),
    .avmms_readdata   (avmms_readdata),
    .coe_irq          (coe_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  src;
    bit          wr;
    bit          rd;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    bit          ci;
    bit          ei;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic vec_t mk(input logic [3:0] src, input bit wr, input bit rd,
                              input logic [1:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input logic [31:0] exp_rd,
                              input bit ci, input bit ei);
    vec_t v;
    v.src = src; v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata;
    v.be = be; v.exp_rd = exp_rd; v.ci = ci; v.ei = ei;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int id);
    irq_src          = v.src;
    avmms_write      = v.wr;
    avmms_read       = v.rd;
    avmms_address    = v.addr;
    avmms_writedata  = v.wdata;
    avmms_byteenable = v.be;
    if (v.rd) exp_q.push_back(v.exp_rd);
    @(posedge clk);
    #1;
    if (v.rd) begin
      if (exp_q.size() == 0) begin
        check($sformatf("scoreboard_empty v%0d", id), 32'd1, 32'd0);
      end else begin
        check($sformatf("readdata v%0d", id), avmms_readdata, exp_q.pop_front());
      end
    end
    if (v.ci) check($sformatf("coe_irq v%0d", id), {31'd0, coe_irq}, {31'd0, v.ei});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // src, wr, rd, addr, wdata, be, exp_rd, chk_irq, exp_irq
    tbl.push_back(mk(4'h0, 0, 1, 2'd0, 32'h0,        4'h0, 32'h0, 1, 0)); // 0
    tbl.push_back(mk(4'h0, 0, 1, 2'd1, 32'h0,        4'h0, 32'h0, 1, 0));
    tbl.push_back(mk(4'h0, 0, 1, 2'd2, 32'h0,        4'h0, 32'h0, 1, 0));
    tbl.push_back(mk(4'h0, 0, 1, 2'd3, 32'h0,        4'h0, 32'h0, 1, 0));
    tbl.push_back(mk(4'h0, 1, 0, 2'd0, 32'h1,        4'hF, 32'h0, 1, 0));
    tbl.push_back(mk(4'h1, 0, 0, 2'd0, 32'h0,        4'h0, 32'h0, 1, 0)); // 5
    tbl.push_back(mk(4'h0, 0, 0, 2'd0, 32'h0,        4'h0, 32'h0, 1, 1));
    tbl.push_back(mk(4'h0, 0, 1, 2'd1, 32'h0,        4'h0, 32'h1, 1, 1));
    tbl.push_back(mk(4'h0, 0, 1, 2'd3, 32'h0,        4'h0, 32'h1, 1, 1));
    tbl.push_back(mk(4'h0, 1, 0, 2'd1, 32'h1,        4'hF, 32'h0, 1, 1));
    tbl.push_back(mk(4'h0, 0, 0, 2'd0, 32'h0,        4'h0, 32'h0, 1, 0)); // 10
    tbl.push_back(mk(4'h0, 1, 0, 2'd0, 32'h0,        4'hF, 32'h0, 1, 0));
    tbl.push_back(mk(4'h4, 0, 0, 2'd0, 32'h0,        4'h0, 32'h0, 1, 0));
    tbl.push_back(mk(4'h0, 0, 0, 2'd0, 32'h0,        4'h0, 32'h0, 1, 0));
    tbl.push_back(mk(4'h0, 0, 1, 2'd1, 32'h0,        4'h0, 32'h4, 1, 0));
    tbl.push_back(mk(4'h0, 1, 0, 2'd0, 32'h4,        4'hF, 32'h0, 1, 0)); // 15
    tbl.push_back(mk(4'h0, 0, 0, 2'd0, 32'h0,        4'h0, 32'h0, 1, 1));
    tbl.push_back(mk(4'h0, 1, 0, 2'd1, 32'h4,        4'hF, 32'h0, 1, 1));
    tbl.push_back(mk(4'h0, 1, 0, 2'd3, 32'h0,        4'h1, 32'h0, 1, 0));
    tbl.push_back(mk(4'h2, 0, 0, 2'd0, 32'h0,        4'h0, 32'h0, 1, 0));
    tbl.push_back(mk(4'h0, 0, 0, 2'd0, 32'h0,        4'h0, 32'h0, 1, 0)); // 20
    tbl.push_back(mk(4'h2, 0, 0, 2'd0, 32'h0,        4'h0, 32'h0, 1, 0));
    tbl.push_back(mk(4'h0, 0, 0, 2'd0, 32'h0,        4'h0, 32'h0, 1, 0));
    tbl.push_back(mk(4'h0, 0, 1, 2'd1, 32'h0,        4'h0, 32'h2, 0, 0));
    tbl.push_back(mk(4'h0, 0, 1, 2'd2, 32'h0,        4'h0, 32'h2, 0, 0));
    tbl.push_back(mk(4'h0, 0, 1, 2'd3, 32'h0,        4'h0, 32'h2, 0, 0)); // 25
    tbl.push_back(mk(4'h0, 1, 0, 2'd2, 32'h2,        4'hF, 32'h0, 0, 0));
    tbl.push_back(mk(4'h0, 0, 1, 2'd2, 32'h0,        4'h0, 32'h0, 0, 0));
    tbl.push_back(mk(4'h1, 0, 0, 2'd0, 32'h0,        4'h0, 32'h0, 0, 0));
    tbl.push_back(mk(4'h0, 0, 0, 2'd0, 32'h0,        4'h0, 32'h0, 0, 0));
    tbl.push_back(mk(4'h1, 1, 0, 2'd1, 32'h1,        4'hF, 32'h0, 0, 0)); // 30
    tbl.push_back(mk(4'h0, 0, 1, 2'd1, 32'h0,        4'h0, 32'h3, 0, 0));
    tbl.push_back(mk(4'h0, 0, 1, 2'd2, 32'h0,        4'h0, 32'h0, 0, 0));
    tbl.push_back(mk(4'h1, 0, 0, 2'd0, 32'h0,        4'h0, 32'h0, 0, 0));
    tbl.push_back(mk(4'h0, 0, 0, 2'd0, 32'h0,        4'h0, 32'h0, 0, 0));
    tbl.push_back(mk(4'h1, 1, 0, 2'd2, 32'h1,        4'hF, 32'h0, 0, 0)); // 35
    tbl.push_back(mk(4'h0, 0, 1, 2'd2, 32'h0,        4'h0, 32'h1, 0, 0));
    tbl.push_back(mk(4'h0, 1, 0, 2'd1, 32'h1,        4'hF, 32'h0, 0, 0));
    tbl.push_back(mk(4'h1, 1, 0, 2'd2, 32'h1,        4'hF, 32'h0, 0, 0));
    tbl.push_back(mk(4'h0, 0, 1, 2'd2, 32'h0,        4'h0, 32'h0, 0, 0));
    tbl.push_back(mk(4'h0, 1, 0, 2'd1, 32'hFFFF_FF00, 4'hE, 32'h0, 0, 0)); // 40
    tbl.push_back(mk(4'h0, 0, 1, 2'd1, 32'h0,        4'h0, 32'h3, 0, 0));
    tbl.push_back(mk(4'h0, 1, 0, 2'd1, 32'hF,        4'h0, 32'h0, 0, 0));
    tbl.push_back(mk(4'h0, 0, 1, 2'd1, 32'h0,        4'h0, 32'h3, 0, 0));
    tbl.push_back(mk(4'h0, 1, 0, 2'd3, 32'h0,        4'hF, 32'h0, 0, 0));
    tbl.push_back(mk(4'h0, 1, 0, 2'd1, 32'hF,        4'h1, 32'h0, 0, 0)); // 45
    tbl.push_back(mk(4'h0, 1, 0, 2'd2, 32'hF,        4'h1, 32'h0, 0, 0));
    tbl.push_back(mk(4'hF, 0, 0, 2'd0, 32'h0,        4'h0, 32'h0, 1, 0));
    tbl.push_back(mk(4'h0, 0, 0, 2'd0, 32'h0,        4'h0, 32'h0, 1, 1));
    tbl.push_back(mk(4'h0, 0, 1, 2'd3, 32'h0,        4'h0, 32'h4, 1, 1));
    tbl.push_back(mk(4'h0, 1, 0, 2'd3, 32'h0,        4'h0, 32'h0, 1, 1)); // 50
    tbl.push_back(mk(4'h0, 0, 1, 2'd3, 32'h0,        4'h0, 32'h4, 0, 0));
    tbl.push_back(mk(4'h0, 1, 1, 2'd0, 32'h0,        4'hF, 32'h4, 1, 1));
    tbl.push_back(mk(4'h0, 0, 1, 2'd0, 32'h0,        4'h0, 32'h0, 1, 0));
    tbl.push_back(mk(4'h0, 1, 0, 2'd0, 32'hFFFF_FFFF, 4'h2, 32'h0, 0, 0));
    tbl.push_back(mk(4'h0, 0, 1, 2'd0, 32'h0,        4'h0, 32'h0, 0, 0)); // 55
    tbl.push_back(mk(4'h0, 1, 0, 2'd0, 32'hFFFF_FFFF, 4'h1, 32'h0, 1, 0));
    tbl.push_back(mk(4'h0, 0, 1, 2'd0, 32'h0,        4'h0, 32'hF, 1, 1));
    tbl.push_back(mk(4'h0, 0, 1, 2'd2, 32'h0,        4'h0, 32'h0, 0, 0));

    reset = 1'b1;
    irq_src = '0; avmms_address = '0; avmms_write = 1'b0;
    avmms_writedata = '0; avmms_byteenable = '0; avmms_read = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_readdata", avmms_readdata, 32'h0);
    check("reset_irq", {31'd0, coe_irq}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run(tbl[i], i);

    // Event counter saturation: preload close to the top, then add edges.
    force dut.event_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.event_cnt_q;
    run(mk(4'hF, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0, 0, 0), 100);
    run(mk(4'h0, 0, 1, 2'd3, 32'h0, 4'h0, 32'hFFFF_FFFF, 0, 0), 101);
    run(mk(4'h1, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0, 0, 0), 102);
    run(mk(4'h0, 0, 1, 2'd3, 32'h0, 4'h0, 32'hFFFF_FFFF, 0, 0), 103);
    run(mk(4'h0, 1, 0, 2'd3, 32'h0, 4'h1, 32'h0, 0, 0), 104);
    run(mk(4'h0, 0, 1, 2'd3, 32'h0, 4'h0, 32'h0, 0, 0), 105);
    run(mk(4'hF, 1, 0, 2'd3, 32'h0, 4'hF, 32'h0, 0, 0), 106);
    run(mk(4'h0, 0, 1, 2'd3, 32'h0, 4'h0, 32'h4, 1, 1), 107);

    // Reset while sources are pending and new edges arrive in the same cycle.
    reset = 1'b1;
    run(mk(4'hF, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0, 1, 0), 110);
    check("midreset_readdata", avmms_readdata, 32'h0);
    reset = 1'b0;
    run(mk(4'h0, 0, 1, 2'd0, 32'h0, 4'h0, 32'h0, 1, 0), 111);
    run(mk(4'h0, 0, 1, 2'd1, 32'h0, 4'h0, 32'h0, 1, 0), 112);
    run(mk(4'h0, 0, 1, 2'd2, 32'h0, 4'h0, 32'h0, 0, 0), 113);
    run(mk(4'h0, 0, 1, 2'd3, 32'h0, 4'h0, 32'h0, 0, 0), 114);

    // A source held high across reset release yields exactly one edge.
    reset = 1'b1;
    run(mk(4'h1, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0, 0, 0), 120);
    reset = 1'b0;
    run(mk(4'h1, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0, 0, 0), 121);
    run(mk(4'h1, 0, 0, 2'd0, 32'h0, 4'h0, 32'h0, 0, 0), 122);
    run(mk(4'h1, 0, 1, 2'd1, 32'h0, 4'h0, 32'h1, 0, 0), 123);
    run(mk(4'h1, 0, 1, 2'd3, 32'h0, 4'h0, 32'h1, 0, 0), 124);
    run(mk(4'h1, 0, 1, 2'd2, 32'h0, 4'h0, 32'h0, 1, 0), 125);

    if (exp_q.size() != 0) check("scoreboard_leftover", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
